// File: rtl/spw_fifo_pkg.sv
// Shared constants and types for the SpaceWire TX character FIFO.
// Packet store-and-forward is selected at build time with FIFO_TX_PKT_CNT_EN.
package spw_fifo_pkg;

    localparam int DEF_DWIDTH = 9;
    localparam int DEF_AWIDTH = 6;

    // The control flag (EOP/EEP marker) always sits in the top bit of a character.
    function automatic int ctrl_bit(input int dwidth);
        return dwidth - 1;
    endfunction

    localparam int CTRL_BIT = ctrl_bit(DEF_DWIDTH);

    // One extra bit beyond the address distinguishes full from empty.
    typedef logic [DEF_AWIDTH:0] fifo_ptr_t;

    localparam logic [DEF_DWIDTH-1:0] CHAR_EOP = 9'h100;
    localparam logic [DEF_DWIDTH-1:0] CHAR_EEP = 9'h101;

endpackage

// File: rtl/spw_fifo_dpram.sv
// Simple dual-port character store: one write port and one registered read port.
// Read-during-write to the same address returns the previous contents.
module spw_fifo_dpram
    import spw_fifo_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    output logic [DWIDTH-1:0] rd_data_o
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [DWIDTH-1:0] rd_data_q;

    // NOTE: the storage array has no reset so it can map onto block RAM; only the read register is cleared.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // NOTE: non-blocking assignments give every flop the value from before the edge, which is what makes same-address reads return old data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/spw_fifo_tx_param.sv
// Parametrised SpaceWire TX character FIFO between the host write port and the TX encoder.
// Define FIFO_TX_PKT_CNT_EN for packet store-and-forward; otherwise it runs cut-through.
module spw_fifo_tx_param
    import spw_fifo_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int AF_LEVEL = 56,
    parameter int AE_LEVEL = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] data_out,
    output logic              write_tx,
    output logic              f_full,
    output logic              f_empty,
    output logic              f_afull,
    output logic              f_aempty,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [AWIDTH:0]   counter
);

    typedef logic [AWIDTH:0] cnt_t;

    localparam cnt_t AF_THR = cnt_t'(AF_LEVEL);
    localparam cnt_t AE_THR = cnt_t'(AE_LEVEL);

    logic wr_blk_q, rd_blk_q;
    logic push, pop, push_drop;
    cnt_t wr_ptr_q, wr_ptr_d;
    cnt_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic full_d, empty_d;
    logic f_full_q, f_empty_q, f_afull_q, f_aempty_q;
    logic overflow_q, overflow_d;
    logic write_tx_q, write_tx_d;
    logic avail;

    // Edge-qualified requests: a held wr_en/rd_en acts only on its first cycle.
    always_comb begin
        push      = wr_en & ~wr_blk_q & ~f_full_q;
        push_drop = wr_en & ~wr_blk_q &  f_full_q;
        pop       = rd_en & ~rd_blk_q & ~f_empty_q;

        wr_ptr_d  = wr_ptr_q + {{AWIDTH{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{AWIDTH{1'b0}}, pop};
        count_d   = wr_ptr_d - rd_ptr_d;

        full_d    = (wr_ptr_d[AWIDTH] != rd_ptr_d[AWIDTH]) &&
                    (wr_ptr_d[AWIDTH-1:0] == rd_ptr_d[AWIDTH-1:0]);
        empty_d   = (wr_ptr_d == rd_ptr_d);

        overflow_d = push_drop | (overflow_q & ~ovf_clr);
    end

`ifdef FIFO_TX_PKT_CNT_EN
    localparam int CTRL = ctrl_bit(DWIDTH);

    // Shadow copy of each slot's control flag so a pop knows at once whether it removes a packet end.
    logic [2**AWIDTH-1:0] ctrl_flag_q;
    cnt_t pkt_count_q, pkt_count_d;
    logic pkt_in, pkt_out;

    always_comb begin
        pkt_in      = push & data_in[CTRL];
        pkt_out     = pop & ctrl_flag_q[rd_ptr_q[AWIDTH-1:0]];
        pkt_count_d = pkt_count_q + {{AWIDTH{1'b0}}, pkt_in} - {{AWIDTH{1'b0}}, pkt_out};
        // A full buffer with no packet end must still drain, or the host could never complete the packet.
        avail       = (pkt_count_q != '0) || (f_full_q && (pkt_count_q == '0));
    end

    always_ff @(posedge clock) begin
        if (push) begin
            ctrl_flag_q[wr_ptr_q[AWIDTH-1:0]] <= data_in[CTRL];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end
`else
    always_comb begin
        avail = (count_q != '0);
    end
`endif

    always_comb begin
        if (rd_en) begin
            write_tx_d = 1'b0;
        end else if (avail) begin
            write_tx_d = 1'b1;
        end else begin
            write_tx_d = write_tx_q;
        end
    end

    // Flags and counter come from next-state values so they are valid the cycle after the push/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_blk_q   <= 1'b0;
            rd_blk_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            f_full_q   <= 1'b0;
            f_empty_q  <= 1'b1;
            f_afull_q  <= 1'b0;
            f_aempty_q <= 1'b1;
            overflow_q <= 1'b0;
            write_tx_q <= 1'b0;
        end else begin
            wr_blk_q   <= wr_en;
            rd_blk_q   <= rd_en;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            f_full_q   <= full_d;
            f_empty_q  <= empty_d;
            f_afull_q  <= (count_d >= AF_THR);
            f_aempty_q <= (count_d <= AE_THR);
            overflow_q <= overflow_d;
            write_tx_q <= write_tx_d;
        end
    end

    // Reading at the next-state pointer puts the new head on data_out one cycle after a pop.
    spw_fifo_dpram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q[AWIDTH-1:0]),
        .wr_data_i (data_in),
        .rd_addr_i (rd_ptr_d[AWIDTH-1:0]),
        .rd_data_o (data_out)
    );

    assign write_tx = write_tx_q;
    assign f_full   = f_full_q;
    assign f_empty  = f_empty_q;
    assign f_afull  = f_afull_q;
    assign f_aempty = f_aempty_q;
    assign overflow = overflow_q;
    assign counter  = count_q;

endmodule

// File: tb/tb_spw_fifo_tx_param.sv
// Directed self-checking bench for spw_fifo_tx_param at default parameters.
// Packet-mode scenarios are compiled in when FIFO_TX_PKT_CNT_EN is defined.
module tb_spw_fifo_tx_param;

    localparam int DW = 9;
    localparam int AW = 6;

    logic          clock;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          write_tx;
    logic          f_full;
    logic          f_empty;
    logic          f_afull;
    logic          f_aempty;
    logic          overflow;
    logic          ovf_clr;
    logic [AW:0]   counter;

    int n_checks = 0;
    int n_pass   = 0;

    spw_fifo_tx_param #(
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .AF_LEVEL (56),
        .AE_LEVEL (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .data_out (data_out),
        .write_tx (write_tx),
        .f_full   (f_full),
        .f_empty  (f_empty),
        .f_afull  (f_afull),
        .f_aempty (f_aempty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .counter  (counter)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        data_in = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        tick();
    endtask

    task automatic pop_word(output logic [DW-1:0] d);
        d     = data_out;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        #1;
        reset = 1'b0;
        #1;
        flags = {f_empty, f_aempty, f_full, f_afull, overflow, write_tx, 2'b00};
        n_checks++;
        if (flags !== 8'b1100_0000) $display("FAIL reset_flags: got %b expected %b", flags, 8'b1100_0000);
        else n_pass++;
        n_checks++;
        if (counter !== 7'd0) $display("FAIL reset_counter: got %0d expected 0", counter);
        else n_pass++;
        n_checks++;
        if (data_out !== 9'h000) $display("FAIL reset_data_out: got %h expected 000", data_out);
        else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_held_write();
        logic [DW-1:0] d;
        data_in = 9'h0A5;
        wr_en   = 1'b1;
        tick();
        n_checks++;
        if (counter !== 7'd1) $display("FAIL held_count_first: got %0d expected 1", counter);
        else n_pass++;
        n_checks++;
        if (f_empty !== 1'b0) $display("FAIL held_empty: got %b expected 0", f_empty);
        else n_pass++;
        repeat (4) tick();
        wr_en = 1'b0;
        n_checks++;
        if (counter !== 7'd1) $display("FAIL held_count_after5: got %0d expected 1", counter);
        else n_pass++;
        tick();
        n_checks++;
        if (data_out !== 9'h0A5) $display("FAIL held_data_out: got %h expected 0a5", data_out);
        else n_pass++;
`ifndef FIFO_TX_PKT_CNT_EN
        n_checks++;
        if (write_tx !== 1'b1) $display("FAIL held_write_tx: got %b expected 1", write_tx);
        else n_pass++;
`endif
        pop_word(d);
        n_checks++;
        if (d !== 9'h0A5) $display("FAIL held_pop_data: got %h expected 0a5", d);
        else n_pass++;
        n_checks++;
        if ({counter, f_empty, write_tx} !== {7'd0, 1'b1, 1'b0})
            $display("FAIL held_after_pop: got cnt=%0d empty=%b wtx=%b expected cnt=0 empty=1 wtx=0", counter, f_empty, write_tx);
        else n_pass++;
    endtask

    task automatic test_full_overflow();
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < 64; i++) push_word(9'h040 + 9'(i));
        n_checks++;
        if ({counter, f_full, f_afull} !== {7'd64, 1'b1, 1'b1})
            $display("FAIL full_state: got cnt=%0d full=%b afull=%b expected cnt=64 full=1 afull=1", counter, f_full, f_afull);
        else n_pass++;
        n_checks++;
        if (write_tx !== 1'b1) $display("FAIL full_write_tx: got %b expected 1", write_tx);
        else n_pass++;
        push_word(9'h1FF);
        n_checks++;
        if ({counter, overflow} !== {7'd64, 1'b1})
            $display("FAIL ovf_set: got cnt=%0d ovf=%b expected cnt=64 ovf=1", counter, overflow);
        else n_pass++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", overflow);
        else n_pass++;
        tick();
        data_in = 9'h1FD;
        wr_en   = 1'b1;
        ovf_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_clr_collide: got %b expected 1", overflow);
        else n_pass++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick();
        // Push and pop together while full: only the pop takes effect.
        d       = data_out;
        data_in = 9'h1FE;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        n_checks++;
        if ({counter, f_full, overflow} !== {7'd63, 1'b0, 1'b1})
            $display("FAIL full_pushpop: got cnt=%0d full=%b ovf=%b expected cnt=63 full=0 ovf=1", counter, f_full, overflow);
        else n_pass++;
        n_checks++;
        if (d !== 9'h040) $display("FAIL full_pushpop_data: got %h expected 040", d);
        else n_pass++;
        tick();
        for (int i = 1; i < 64; i++) begin
            pop_word(d);
            n_checks++;
            if (d !== 9'h040 + 9'(i)) $display("FAIL full_drain[%0d]: got %h expected %h", i, d, 9'h040 + 9'(i));
            else n_pass++;
        end
        n_checks++;
        if ({counter, f_empty} !== {7'd0, 1'b1})
            $display("FAIL drained: got cnt=%0d empty=%b expected cnt=0 empty=1", counter, f_empty);
        else n_pass++;
        pop_word(d);
        n_checks++;
        if ({counter, f_empty} !== {7'd0, 1'b1})
            $display("FAIL pop_empty: got cnt=%0d empty=%b expected cnt=0 empty=1", counter, f_empty);
        else n_pass++;
        push_word(9'h077);
        pop_word(d);
        n_checks++;
        if (d !== 9'h077) $display("FAIL pop_empty_ptr: got %h expected 077", d);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] d;
        do_reset();
        data_in = 9'h033;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        n_checks++;
        if (counter !== 7'd1) $display("FAIL empty_pushpop: got %0d expected 1", counter);
        else n_pass++;
        tick();
        n_checks++;
        if (data_out !== 9'h033) $display("FAIL empty_pushpop_data: got %h expected 033", data_out);
        else n_pass++;
        do_reset();
        for (int i = 0; i < 10; i++) push_word(9'h010 + 9'(i));
`ifndef FIFO_TX_PKT_CNT_EN
        n_checks++;
        if (write_tx !== 1'b1) $display("FAIL simul_wtx_pre: got %b expected 1", write_tx);
        else n_pass++;
`endif
        d       = data_out;
        data_in = 9'h01A;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        n_checks++;
        if (counter !== 7'd10) $display("FAIL simul_count: got %0d expected 10", counter);
        else n_pass++;
        n_checks++;
        if (d !== 9'h010) $display("FAIL simul_pop_data: got %h expected 010", d);
        else n_pass++;
`ifndef FIFO_TX_PKT_CNT_EN
        n_checks++;
        if (write_tx !== 1'b0) $display("FAIL simul_wtx_clr: got %b expected 0", write_tx);
        else n_pass++;
`endif
        tick();
`ifndef FIFO_TX_PKT_CNT_EN
        n_checks++;
        if (write_tx !== 1'b1) $display("FAIL simul_wtx_reset: got %b expected 1", write_tx);
        else n_pass++;
`endif
        for (int i = 1; i <= 10; i++) begin
            pop_word(d);
            n_checks++;
            if (d !== 9'h010 + 9'(i)) $display("FAIL simul_order[%0d]: got %h expected %h", i, d, 9'h010 + 9'(i));
            else n_pass++;
        end
    endtask

    task automatic test_wrap_thresholds();
        logic [DW-1:0] q[$];
        logic [DW-1:0] d, exp_d;
        logic [10:0]   got_v, exp_v;
        int            pushed;
        int            sz;
        bit            up;
        do_reset();
        pushed = 0;
        up     = 1'b1;
        while (pushed < 200 || q.size() > 0) begin
            if (up && pushed < 200) begin
                d = {1'b0, 8'(pushed)};
                push_word(d);
                q.push_back(d);
                pushed++;
                if (q.size() == 60 || pushed == 200) up = 1'b0;
            end else begin
                pop_word(d);
                exp_d = q.pop_front();
                n_checks++;
                if (d !== exp_d) $display("FAIL wrap_data: got %h expected %h", d, exp_d);
                else n_pass++;
                if (q.size() == 0) up = 1'b1;
            end
            sz    = q.size();
            got_v = {counter, f_full, f_afull, f_aempty, f_empty};
            exp_v = {7'(sz), sz == 64, sz >= 56, sz <= 4, sz == 0};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL wrap_flags: got cnt/full/afull/aempty/empty=%b expected %b", got_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] d;
        logic [7:0]    flags;
        do_reset();
        for (int i = 0; i < 30; i++) push_word(9'h080 + 9'(i));
        data_in = 9'h0FF;
        wr_en   = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        flags = {f_empty, f_aempty, f_full, f_afull, overflow, write_tx, 2'b00};
        n_checks++;
        if (flags !== 8'b1100_0000) $display("FAIL async_flags: got %b expected %b", flags, 8'b1100_0000);
        else n_pass++;
        n_checks++;
        if ({counter, data_out} !== {7'd0, 9'h000})
            $display("FAIL async_cnt_data: got cnt=%0d data=%h expected cnt=0 data=000", counter, data_out);
        else n_pass++;
        wr_en = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        push_word(9'h05A);
        n_checks++;
        if ({counter, data_out} !== {7'd1, 9'h05A})
            $display("FAIL async_next_push: got cnt=%0d data=%h expected cnt=1 data=05a", counter, data_out);
        else n_pass++;
        pop_word(d);
        n_checks++;
        if (d !== 9'h05A) $display("FAIL async_readback: got %h expected 05a", d);
        else n_pass++;
    endtask

`ifdef FIFO_TX_PKT_CNT_EN
    task automatic test_packet();
        logic [DW-1:0] d;
        logic [DW-1:0] exp_seq [4];
        exp_seq = '{9'h001, 9'h002, 9'h003, 9'h100};
        do_reset();
        for (int i = 0; i < 3; i++) push_word(exp_seq[i]);
        tick();
        n_checks++;
        if (write_tx !== 1'b0) $display("FAIL pkt_no_eop: got %b expected 0", write_tx);
        else n_pass++;
        push_word(exp_seq[3]);
        n_checks++;
        if (write_tx !== 1'b1) $display("FAIL pkt_eop: got %b expected 1", write_tx);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            pop_word(d);
            n_checks++;
            if (d !== exp_seq[i]) $display("FAIL pkt_order[%0d]: got %h expected %h", i, d, exp_seq[i]);
            else n_pass++;
        end
        n_checks++;
        if ({counter, write_tx} !== {7'd0, 1'b0})
            $display("FAIL pkt_drained: got cnt=%0d wtx=%b expected cnt=0 wtx=0", counter, write_tx);
        else n_pass++;
    endtask
`endif

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        data_in = '0;
        test_reset();
        test_held_write();
        test_full_overflow();
        test_simultaneous();
        test_wrap_thresholds();
        test_async_reset();
`ifdef FIFO_TX_PKT_CNT_EN
        test_packet();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
